// File: rtl/forth_pkg.sv
// Shared definitions for the forth core and its fetch stage.
// This covers the instruction field layout, the opcode map and a field-split helper.
package forth_pkg;

  localparam int INSN_W     = 8;
  localparam int POPS_W     = 2;
  localparam int OPCODE_W   = 6;

  localparam int POPS_MSB   = 7;
  localparam int POPS_LSB   = 6;
  localparam int OPCODE_MSB = 5;
  localparam int OPCODE_LSB = 0;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LIT  = 6'h01;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_AND  = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_OR   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 6'h06;
  localparam logic [OPCODE_W-1:0] OP_DUP  = 6'h07;
  localparam logic [OPCODE_W-1:0] OP_DROP = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_SWAP = 6'h09;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 6'h10;
  localparam logic [OPCODE_W-1:0] OP_JZ   = 6'h11;
  localparam logic [OPCODE_W-1:0] OP_CALL = 6'h12;
  localparam logic [OPCODE_W-1:0] OP_RET  = 6'h13;
  localparam logic [OPCODE_W-1:0] OP_HALT = 6'h3F;

  typedef struct packed {
    logic [POPS_W-1:0]   pops;
    logic [OPCODE_W-1:0] opcode;
  } insn_t;

  function automatic insn_t split_insn(input logic [INSN_W-1:0] b);
    insn_t f;
    f.pops   = b[POPS_MSB:POPS_LSB];
    f.opcode = b[OPCODE_MSB:OPCODE_LSB];
    return f;
  endfunction

endpackage

// File: rtl/forth_code_ram.sv
// Byte-wide code memory with one synchronous read port and one write port.
// When the read and write addresses match in the same cycle, the read returns the old byte.
module forth_code_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset so it maps onto block RAM. Program contents survive a core reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/forth_fetch.sv
// Instruction fetch stage for the forth core. It holds the fetch PC, one in-flight read and a prefetch FIFO.
// Instructions are delivered pre-split over a valid/ready handshake, and a jump strobe redirects the fetch stream.
module forth_fetch
  import forth_pkg::*;
#(
  parameter int            AW         = 8,
  parameter int            FIFO_DEPTH = 2,
  parameter logic [AW-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [INSN_W-1:0]   prog_wdata,
  input  logic                jump_valid,
  input  logic [AW-1:0]       jump_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSN_W-1:0]   out_insn,
  output logic [POPS_W-1:0]   out_pops,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [AW-1:0]       out_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [AW-1:0]     pc;
  logic              inflight;
  logic [AW-1:0]     inflight_pc;
  logic [INSN_W-1:0] fifo_insn [FIFO_DEPTH];
  logic [AW-1:0]     fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              pop, push, issue;
  logic [AW-1:0]     rd_addr;
  logic [OCC_W-1:0]  occupancy, limit;
  logic [INSN_W-1:0] ram_rdata;
  insn_t             head_fields;

  forth_code_ram #(.AW(AW), .DW(INSN_W)) u_code_ram (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    out_valid = (count != '0);
    pop       = out_valid & out_ready & ~jump_valid;
    push      = inflight & ~jump_valid;
    occupancy = OCC_W'(count) + OCC_W'(inflight);
    limit     = OCC_W'(FIFO_DEPTH) + OCC_W'(pop);
    // A redirect clears both the FIFO and the in-flight read, so its issue needs no room check.
    issue     = run & rst & (jump_valid | (occupancy < limit));
    rd_addr   = jump_valid ? jump_addr : pc;
  end

  // NOTE: state registers use non-blocking assignments, so every update in a cycle sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= rd_addr;
      if (jump_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        pc     <= run ? jump_addr + 1'b1 : jump_addr;
      end else begin
        if (issue) pc <= pc + 1'b1;
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // The issue check guarantees room, so a returning byte always has a free slot.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_insn[wr_ptr] <= ram_rdata;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

  // Outputs read as zero while empty, which also covers the reset state.
  assign out_insn    = out_valid ? fifo_insn[rd_ptr] : '0;
  assign out_pc      = out_valid ? fifo_pc[rd_ptr]   : '0;
  assign head_fields = split_insn(out_insn);
  assign out_pops    = head_fields.pops;
  assign out_opcode  = head_fields.opcode;

endmodule
